cmem_arbiter: RTL and testbench

CMEM_ARBITER -- requirements
Module: cmem_arbiter

---
 rtl/cmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_arbiter.sv
// cmem_arbiter: shares one asynchronous 16-bit memory between three requesters.
//   display  (DSP_*) : read-only line-fetch port, highest priority, never preempted
//   capture  (CAP_*) : write-only port
//   CPU      (CPU_*) : read/write port; outranks capture once it has waited STARVE_MAX cycles
// Every access is 1 SETUP + ACC_CYC STROBE + 1 HOLD cycle. Requests are level
// and are sampled in IDLE and in HOLD, so a held request gets back-to-back accesses.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   DSP_REQ/ADDR, DSP_RDATA/VALID  display read request and returned data
//   CAP_REQ/ADDR/WDATA, CAP_ACK    capture write request and completion
//   CPU_REQ/WE/ADDR/WDATA, CPU_RDATA/ACK  CPU request and completion
//   MEM_*                          memory bus (strobes active-low), MEM_DRV = data-bus drive enable
//   GRANT                          current owner: 00 none, 01 display, 10 capture, 11 CPU
//
// state  | meaning
// IDLE   | no access in progress, bus released, requests sampled
// SETUP  | address/data/direction presented, chip enabled
// STROBE | nOE (read) or nWE (write) asserted for ACC_CYC cycles
// HOLD   | strobe released, ACK/VALID pulses, requests sampled for the next access
module cmem_arbiter #(
  parameter int ACC_CYC    = 4,
  parameter int STARVE_MAX = 63
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DSP_REQ,
  input  logic [23:1] DSP_ADDR,
  output logic [15:0] DSP_RDATA,
  output logic        DSP_VALID,
  input  logic        CAP_REQ,
  input  logic [23:1] CAP_ADDR,
  input  logic [15:0] CAP_WDATA,
  output logic        CAP_ACK,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [23:1] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic [15:0] CPU_RDATA,
  output logic        CPU_ACK,
  output logic [23:1] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  input  logic [15:0] MEM_DIN,
  output logic        MEM_DRV,
  output logic        MEM_nCE,
  output logic        MEM_nOE,
  output logic        MEM_nWE,
  output logic [1:0]  GRANT
);

  localparam int SW = ($clog2(STARVE_MAX + 1) > 6) ? $clog2(STARVE_MAX + 1) : 6;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_DSP  = 2'b01;
  localparam logic [1:0] G_CAP  = 2'b10;
  localparam logic [1:0] G_CPU  = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [1:0]    grant_q;
  logic [1:0]    pick;
  logic          we_q;
  logic [23:1]   addr_q;
  logic [15:0]   dout_q;
  logic [15:0]   dsp_rdata_q;
  logic [15:0]   cpu_rdata_q;
  logic [SW-1:0] starve_cnt;
  logic          sample;
  logic          last_strobe;
  logic          cpu_starved;

  assign sample      = (state_q == IDLE) || (state_q == HOLD);
  assign last_strobe = (state_q == STROBE) && (cnt_q == 4'(ACC_CYC - 1));
  assign cpu_starved = (starve_cnt == SW'(STARVE_MAX));

  // Display always wins; a starved CPU jumps ahead of capture only.
  always_comb begin
    pick = G_NONE;
    if (DSP_REQ)                      pick = G_DSP;
    else if (CPU_REQ && cpu_starved)  pick = G_CPU;
    else if (CAP_REQ)                 pick = G_CAP;
    else if (CPU_REQ)                 pick = G_CPU;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick != G_NONE) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (last_strobe) state_d = HOLD;
      HOLD:    state_d = (pick != G_NONE) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: grant/address/data latch, strobe counter, read capture, starve counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      grant_q     <= G_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      dsp_rdata_q <= '0;
      cpu_rdata_q <= '0;
      starve_cnt  <= '0;
    end else begin
      // Counter runs only in STROBE, so it is back at zero on every SETUP.
      if (state_q == STROBE) cnt_q <= cnt_q + 4'd1;
      else                   cnt_q <= '0;

      if (sample) begin
        grant_q <= pick;
        case (pick)
          G_DSP: begin
            addr_q <= DSP_ADDR;
            dout_q <= '0;
            we_q   <= 1'b0;
          end
          G_CAP: begin
            addr_q <= CAP_ADDR;
            dout_q <= CAP_WDATA;
            we_q   <= 1'b1;
          end
          G_CPU: begin
            addr_q <= CPU_ADDR;
            dout_q <= CPU_WE ? CPU_WDATA : 16'h0000;
            we_q   <= CPU_WE;
          end
          default: ;
        endcase
      end

      if (last_strobe && !we_q) begin
        if (grant_q == G_DSP) dsp_rdata_q <= MEM_DIN;
        if (grant_q == G_CPU) cpu_rdata_q <= MEM_DIN;
      end

      // Counts only while the CPU is actually waiting on someone else.
      if (!CPU_REQ)
        starve_cnt <= '0;
      else if ((sample && pick == G_CPU) || grant_q == G_CPU)
        starve_cnt <= '0;
      else if (!cpu_starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Output logic
  always_comb begin
    MEM_nCE   = (state_q == IDLE);
    MEM_DRV   = (state_q != IDLE) && we_q;
    MEM_nWE   = !((state_q == STROBE) && we_q);
    MEM_nOE   = !(((state_q == SETUP) || (state_q == STROBE)) && !we_q);
    DSP_VALID = (state_q == HOLD) && (grant_q == G_DSP);
    CAP_ACK   = (state_q == HOLD) && (grant_q == G_CAP);
    CPU_ACK   = (state_q == HOLD) && (grant_q == G_CPU);
    GRANT     = grant_q;
    MEM_ADDR  = addr_q;
    MEM_DOUT  = dout_q;
    DSP_RDATA = dsp_rdata_q;
    CPU_RDATA = cpu_rdata_q;
  end

endmodule

// File: tb/tb_cmem_arbiter.sv
// Bench for cmem_arbiter: directed steps, expected accesses queued per port and
// checked by a bus monitor as the ACK/VALID pulses come out.
module tb_cmem_arbiter;

  localparam int ACC = 4;
  localparam int SMAX = 63;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DSP_REQ, CAP_REQ, CPU_REQ, CPU_WE;
  logic [23:1] DSP_ADDR, CAP_ADDR, CPU_ADDR;
  logic [15:0] CAP_WDATA, CPU_WDATA;
  logic [15:0] DSP_RDATA, CPU_RDATA;
  logic        DSP_VALID, CAP_ACK, CPU_ACK;
  logic [23:1] MEM_ADDR;
  logic [15:0] MEM_DOUT, MEM_DIN;
  logic        MEM_DRV, MEM_nCE, MEM_nOE, MEM_nWE;
  logic [1:0]  GRANT;

  always #5 CLK = ~CLK;

  cmem_arbiter #(.ACC_CYC(ACC), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .DSP_REQ(DSP_REQ), .DSP_ADDR(DSP_ADDR), .DSP_RDATA(DSP_RDATA), .DSP_VALID(DSP_VALID),
    .CAP_REQ(CAP_REQ), .CAP_ADDR(CAP_ADDR), .CAP_WDATA(CAP_WDATA), .CAP_ACK(CAP_ACK),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK),
    .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT), .MEM_DIN(MEM_DIN), .MEM_DRV(MEM_DRV),
    .MEM_nCE(MEM_nCE), .MEM_nOE(MEM_nOE), .MEM_nWE(MEM_nWE), .GRANT(GRANT)
  );

  // Memory model: fixed pattern, one special word at the top address, junk when not output-enabled.
  function automatic logic [15:0] model_rd(input logic [23:1] a);
    return (a == 23'h7FFFFF) ? 16'h1234 : (a[16:1] ^ 16'hC3C3);
  endfunction
  assign MEM_DIN = MEM_nOE ? 16'hDEAD : model_rd(MEM_ADDR);

  typedef struct {
    logic [23:1] addr;
    logic [15:0] data;
    logic        we;
  } exp_t;

  exp_t dsp_q[$], cap_q[$], cpu_q[$];
  int tests = 0;
  int fails = 0;
  int wecnt = 0;
  int dsp_cnt = 0, cap_cnt = 0, cpu_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [23:1] a, input logic [15:0] d, input logic w);
    exp_t e;
    e.addr = a; e.data = d; e.we = w;
    return e;
  endfunction

  // Bus monitor / scoreboard
  always @(negedge CLK) begin
    exp_t h;
    if (RST) begin
      wecnt = 0;
    end else begin
      if (!MEM_nWE) wecnt++;
      if (!MEM_nCE && GRANT == 2'b10 && cap_q.size() > 0) begin
        chk("cap_addr", MEM_ADDR, cap_q[0].addr);
        chk("cap_dout", MEM_DOUT, cap_q[0].data);
        chk("cap_drv", MEM_DRV, 1'b1);
        chk("cap_noe", MEM_nOE, 1'b1);
      end
      if (!MEM_nCE && GRANT == 2'b01 && dsp_q.size() > 0) begin
        chk("dsp_addr", MEM_ADDR, dsp_q[0].addr);
        chk("dsp_drv", MEM_DRV, 1'b0);
        chk("dsp_nwe", MEM_nWE, 1'b1);
      end
      if (!MEM_nCE && GRANT == 2'b11 && cpu_q.size() > 0) begin
        chk("cpu_addr", MEM_ADDR, cpu_q[0].addr);
        chk("cpu_drv", MEM_DRV, cpu_q[0].we);
        if (cpu_q[0].we) chk("cpu_dout", MEM_DOUT, cpu_q[0].data);
      end
      if (DSP_VALID) begin
        dsp_cnt++;
        chk("dsp_expected", dsp_q.size() > 0, 1'b1);
        if (dsp_q.size() > 0) begin
          h = dsp_q.pop_front();
          chk("dsp_rdata", DSP_RDATA, model_rd(h.addr));
          chk("dsp_hold_noe", MEM_nOE, 1'b1);
        end
      end
      if (CAP_ACK) begin
        cap_cnt++;
        chk("cap_expected", cap_q.size() > 0, 1'b1);
        if (cap_q.size() > 0) begin
          h = cap_q.pop_front();
          chk("cap_nwe_cycles", wecnt, ACC);
        end
      end
      if (CPU_ACK) begin
        cpu_cnt++;
        chk("cpu_expected", cpu_q.size() > 0, 1'b1);
        if (cpu_q.size() > 0) begin
          h = cpu_q.pop_front();
          if (h.we) chk("cpu_nwe_cycles", wecnt, ACC);
          else begin
            chk("cpu_rdata", CPU_RDATA, model_rd(h.addr));
            chk("cpu_hold_noe", MEM_nOE, 1'b1);
          end
        end
      end
      if (DSP_VALID || CAP_ACK || CPU_ACK) wecnt = 0;
    end
  end

  initial begin
    int idx, n, last, c0, e, exp_e, k;
    bit done;
    RST = 1'b1;
    DSP_REQ = 0; CAP_REQ = 0; CPU_REQ = 0; CPU_WE = 0;
    DSP_ADDR = '0; CAP_ADDR = '0; CPU_ADDR = '0; CAP_WDATA = '0; CPU_WDATA = '0;
    repeat (3) @(negedge CLK);

    // Reset state, with a capture request already waiting
    CAP_ADDR = 23'h000123; CAP_WDATA = 16'hA5A5; CAP_REQ = 1'b1;
    @(negedge CLK);
    chk("rst_nce", MEM_nCE, 1'b1);
    chk("rst_noe", MEM_nOE, 1'b1);
    chk("rst_nwe", MEM_nWE, 1'b1);
    chk("rst_drv", MEM_DRV, 1'b0);
    chk("rst_addr", MEM_ADDR, 23'h0);
    chk("rst_dout", MEM_DOUT, 16'h0);
    chk("rst_grant", GRANT, 2'b00);
    chk("rst_acks", {DSP_VALID, CAP_ACK, CPU_ACK}, 3'b000);
    chk("rst_rdata", {DSP_RDATA, CPU_RDATA}, 32'h0);
    chk("rst_starve", dut.starve_cnt, 0);

    // Single capture write; arbitration on the first cycle out of reset
    cap_q.push_back(mk(23'h000123, 16'hA5A5, 1'b1));
    RST = 1'b0;
    @(negedge CLK);
    chk("first_grant", GRANT, 2'b10);
    idx = 0; done = 0;
    while (!done && idx < 20) begin
      if (CAP_ACK) begin done = 1; CAP_REQ = 1'b0; end
      else begin @(negedge CLK); idx++; end
    end
    chk("cap_ack_seen", done, 1'b1);
    chk("cap_ack_latency", idx, ACC + 1);
    @(negedge CLK);
    chk("idle_grant", GRANT, 2'b00);
    chk("idle_nce", MEM_nCE, 1'b1);

    // CPU read from top address
    cpu_q.push_back(mk(23'h7FFFFF, 16'h0, 1'b0));
    CPU_ADDR = 23'h7FFFFF; CPU_WE = 1'b0; CPU_REQ = 1'b1;
    idx = 0; done = 0;
    while (!done && idx < 20) begin
      @(negedge CLK); idx++;
      if (CPU_ACK) begin done = 1; CPU_REQ = 1'b0; chk("cpu_rd_1234", CPU_RDATA, 16'h1234); end
    end
    chk("cpu_ack_seen", done, 1'b1);
    repeat (3) @(negedge CLK);
    chk("cpu_rdata_held", CPU_RDATA, 16'h1234);

    // Display and capture together: display first, capture back-to-back
    dsp_q.push_back(mk(23'h000456, 16'h0, 1'b0));
    cap_q.push_back(mk(23'h000789, 16'h0F0F, 1'b1));
    DSP_ADDR = 23'h000456; DSP_REQ = 1'b1;
    CAP_ADDR = 23'h000789; CAP_WDATA = 16'h0F0F; CAP_REQ = 1'b1;
    @(negedge CLK);
    chk("pri_dsp_first", GRANT, 2'b01);
    idx = 0; done = 0;
    while (!done && idx < 20) begin
      if (DSP_VALID) begin done = 1; DSP_REQ = 1'b0; end
      else begin @(negedge CLK); idx++; end
    end
    chk("pri_dsp_valid", done, 1'b1);
    @(negedge CLK);
    chk("b2b_cap_grant", GRANT, 2'b10);
    chk("b2b_no_idle", MEM_nCE, 1'b0);
    idx = 0; done = 0;
    while (!done && idx < 20) begin
      if (CAP_ACK) begin done = 1; CAP_REQ = 1'b0; end
      else begin @(negedge CLK); idx++; end
    end
    chk("b2b_cap_ack", done, 1'b1);
    repeat (2) @(negedge CLK);

    // Ten back-to-back display reads while capture waits
    c0 = cap_cnt;
    DSP_ADDR = 23'h000100; DSP_REQ = 1'b1;
    dsp_q.push_back(mk(23'h000100, 16'h0, 1'b0));
    CAP_ADDR = 23'h000999; CAP_WDATA = 16'h5555; CAP_REQ = 1'b1;
    n = 0; last = 0; idx = 0;
    while (n < 10 && idx < 120) begin
      @(negedge CLK); idx++;
      if (DSP_VALID) begin
        n++;
        if (n > 1) chk("dsp_spacing", idx - last, ACC + 2);
        last = idx;
        if (n == 10) begin DSP_REQ = 1'b0; CAP_REQ = 1'b0; end
        else begin
          DSP_ADDR = DSP_ADDR + 23'd1;
          dsp_q.push_back(mk(DSP_ADDR, 16'h0, 1'b0));
        end
      end
    end
    chk("dsp_ten_valids", n, 10);
    chk("cap_starved_by_dsp", cap_cnt - c0, 0);
    repeat (2) @(negedge CLK);

    // Capture and CPU both held: CPU wins at the first HOLD after starve saturates
    k = ((SMAX + ACC + 1) / (ACC + 2)) * (ACC + 2);
    exp_e = k + 1;
    c0 = cap_cnt;
    for (int i = 0; i < k / (ACC + 2); i++) cap_q.push_back(mk(23'h000AAA, 16'h1111, 1'b1));
    cpu_q.push_back(mk(23'h000BBB, 16'h2222, 1'b1));
    CAP_ADDR = 23'h000AAA; CAP_WDATA = 16'h1111; CAP_REQ = 1'b1;
    CPU_ADDR = 23'h000BBB; CPU_WDATA = 16'h2222; CPU_WE = 1'b1; CPU_REQ = 1'b1;
    e = 0; done = 0;
    while (!done && e < 200) begin
      @(negedge CLK); e++;
      if (GRANT == 2'b11) begin done = 1; CAP_REQ = 1'b0; end
    end
    chk("starve_cpu_granted", done, 1'b1);
    chk("starve_grant_cycle", e, exp_e);
    chk("starve_cleared", dut.starve_cnt, 0);
    chk("starve_cap_count", cap_cnt - c0, k / (ACC + 2));
    idx = 0; done = 0;
    while (!done && idx < 20) begin
      if (CPU_ACK) begin done = 1; CPU_REQ = 1'b0; CPU_WE = 1'b0; end
      else begin @(negedge CLK); idx++; end
    end
    chk("starve_cpu_ack", done, 1'b1);
    repeat (2) @(negedge CLK);

    // Reset in the middle of a write strobe
    c0 = cap_cnt;
    cap_q.push_back(mk(23'h000321, 16'h7777, 1'b1));
    CAP_ADDR = 23'h000321; CAP_WDATA = 16'h7777; CAP_REQ = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid_strobe_nwe", MEM_nWE, 1'b0);
    RST = 1'b1; CAP_REQ = 1'b0;
    @(negedge CLK);
    chk("rst_mid_nwe", MEM_nWE, 1'b1);
    chk("rst_mid_nce", MEM_nCE, 1'b1);
    chk("rst_mid_grant", GRANT, 2'b00);
    chk("rst_mid_drv", MEM_DRV, 1'b0);
    chk("rst_mid_addr", MEM_ADDR, 23'h0);
    chk("rst_mid_ack", CAP_ACK, 1'b0);
    cap_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    chk("rst_mid_no_ack", cap_cnt - c0, 0);
    chk("rst_mid_rdata", CPU_RDATA, 16'h0);
    chk("queues_drained", dsp_q.size() + cap_q.size() + cpu_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
